receive_ascii_as_binary: RTL and testbench

- Inverse of send_binary_as_ascii: parses ASCII '0'/'1' digit strings (MSB first) from the uart_rx6 output byte stream into M-bit binary words.
- Each word is terminated by CR (0x0D) or LF (0x0A).
- Finished words are presented to downstream logic (weight/input loading for the perceptron) on a one-entry valid/ready output register.
- Format, overflow and overrun errors are flagged with single-cycle pulses.

---
 rtl/receive_ascii_as_binary.sv | 154 +++++++++++++++
 tb/tb_receive_ascii_as_binary.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/receive_ascii_as_binary.sv
// Purpose : parse MSB-first ASCII '0'/'1' strings, terminated by CR or LF,
//           into M-bit binary words for the perceptron weight/input loader.
// Latency : 1 clk from the terminator edge to out_valid / binary_out.
// Backpr. : one-entry output register; a word completed while it is still
//           full and not being drained is dropped and err_overrun pulses.
//
// Ports:
//   clk          system clock (baud_clk domain)
//   reset        asynchronous, active-high reset
//   ascii_in     received character from the UART
//   data_present ascii_in valid; one character consumed per edge where high
//   binary_out   completed word, right-aligned and zero-extended
//   out_valid    binary_out holds a word not yet taken downstream
//   out_ready    downstream takes binary_out on this edge
//   err_format   1-cycle pulse: illegal character inside a word
//   err_overflow 1-cycle pulse: more than M digits in a word
//   err_overrun  1-cycle pulse: finished word lost because output was full
module receive_ascii_as_binary #(
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   ascii_in,
  input  logic         data_present,
  output logic [M-1:0] binary_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         err_format,
  output logic         err_overflow,
  output logic         err_overrun
);

  localparam int CW = $clog2(M + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state;
  logic [M-1:0]    acc;
  logic [CW-1:0]   count;

  // Character classification. Anything with bit 7 set can never match the
  // digit or terminator codes, so it falls into OTHER automatically.
  logic is_digit;
  logic is_term;
  logic digit_bit;

  always_comb begin
    is_digit  = (ascii_in == 8'h30) || (ascii_in == 8'h31);
    is_term   = (ascii_in == 8'h0A) || (ascii_in == 8'h0D);
    digit_bit = ascii_in[0];
  end

  // A word completes only on a terminator that follows at least one digit
  // of a clean (non-discarded) word.
  logic word_done;
  logic out_take;
  logic out_free;

  always_comb begin
    word_done = data_present && (state == ACCUM) && is_term;
    out_take  = out_valid && out_ready;
    // The output slot can accept a new word if it is empty, or if the
    // pending word is being taken on this same edge.
    out_free  = !out_valid || out_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      acc          <= '0;
      count        <= '0;
      binary_out   <= '0;
      out_valid    <= 1'b0;
      err_format   <= 1'b0;
      err_overflow <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      // Error outputs are pulses: cleared every cycle unless re-raised below.
      err_format   <= 1'b0;
      err_overflow <= 1'b0;
      err_overrun  <= 1'b0;

      // ---------------- parser FSM ----------------
      if (data_present) begin
        case (state)
          IDLE: begin
            if (is_digit) begin
              acc   <= {{(M-1){1'b0}}, digit_bit};
              count <= CW'(1);
              state <= ACCUM;
            end else if (is_term) begin
              // Empty line or the LF half of CRLF: nothing to emit.
              state <= IDLE;
            end else begin
              err_format <= 1'b1;
              state      <= DISCARD;
            end
          end

          ACCUM: begin
            if (is_digit) begin
              if (count == CW'(M)) begin
                err_overflow <= 1'b1;
                state        <= DISCARD;
              end else begin
                acc   <= {acc[M-2:0], digit_bit};
                count <= count + CW'(1);
              end
            end else if (is_term) begin
              count <= '0;
              state <= IDLE;
            end else begin
              err_format <= 1'b1;
              state      <= DISCARD;
            end
          end

          DISCARD: begin
            // Swallow the rest of a bad word silently; only one error pulse
            // is reported per word.
            if (is_term) begin
              count <= '0;
              state <= IDLE;
            end
          end

          default: begin
            count <= '0;
            state <= IDLE;
          end
        endcase
      end

      // ---------------- output register ----------------
      if (word_done) begin
        if (out_free) begin
          binary_out <= acc;
          out_valid  <= 1'b1;
        end else begin
          // Slot is full and not draining: keep the old word, drop the new.
          err_overrun <= 1'b1;
        end
      end else if (out_take) begin
        // binary_out deliberately keeps its last value after the transfer.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_receive_ascii_as_binary.sv
// Bench for receive_ascii_as_binary (M=8): expected words are queued as the
// strings are sent and popped whenever the output handshake completes;
// error pulses are counted per cycle and compared against expected totals.
module tb_receive_ascii_as_binary;

  localparam int M = 8;

  logic         clk;
  logic         reset;
  logic [7:0]   ascii_in;
  logic         data_present;
  logic [M-1:0] binary_out;
  logic         out_valid;
  logic         out_ready;
  logic         err_format;
  logic         err_overflow;
  logic         err_overrun;

  receive_ascii_as_binary #(.M(M)) dut (
    .clk          (clk),
    .reset        (reset),
    .ascii_in     (ascii_in),
    .data_present (data_present),
    .binary_out   (binary_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .err_format   (err_format),
    .err_overflow (err_overflow),
    .err_overrun  (err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  logic [M-1:0] exp_q[$];

  int fmt_cnt = 0;
  int ovf_cnt = 0;
  int ovr_cnt = 0;
  int exp_fmt = 0;
  int exp_ovf = 0;
  int exp_ovr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: a transfer happens on the next posedge whenever both
  // out_valid and out_ready are high mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (err_format)   fmt_cnt++;
      if (err_overflow) ovf_cnt++;
      if (err_overrun)  ovr_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0)
          check("unexpected_word", {24'd0, binary_out}, 32'hFFFF_FFFF);
        else
          check("word", {24'd0, binary_out}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    ascii_in     = b;
    data_present = 1'b1;
    @(posedge clk);
    #1;
    data_present = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_errs(input string tag);
    check({tag, "_err_format"},   fmt_cnt, exp_fmt);
    check({tag, "_err_overflow"}, ovf_cnt, exp_ovf);
    check({tag, "_err_overrun"},  ovr_cnt, exp_ovr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    ascii_in     = 8'h00;
    data_present = 1'b0;
    out_ready    = 1'b0;
    idle(2);
    check("rst_out_valid",  out_valid,    0);
    check("rst_binary_out", binary_out,   0);
    check("rst_err_format", err_format,   0);
    check("rst_err_ovf",    err_overflow, 0);
    check("rst_err_ovr",    err_overrun,  0);
    reset = 1'b0;
    idle(1);

    // 1: full 8-digit word, drained immediately.
    out_ready = 1'b1;
    exp_q.push_back(8'hB3);
    send_str("10110011");
    send_byte(8'h0A);
    check("t1_valid_after_lf", out_valid, 1);
    check("t1_value", binary_out, 8'hB3);
    idle(1);
    check("t1_valid_one_cycle", out_valid, 0);
    check_errs("t1");

    // 2: CRLF with downstream stalled; LF must not produce a second word.
    out_ready = 1'b0;
    exp_q.push_back(8'h05);
    send_str("101");
    send_byte(8'h0D);
    send_byte(8'h0A);
    check("t2_valid_held", out_valid, 1);
    check("t2_value", binary_out, 8'h05);
    idle(3);
    check("t2_still_valid", out_valid, 1);
    check_errs("t2");
    out_ready = 1'b1;
    idle(1);
    check("t2_valid_falls", out_valid, 0);
    check("t2_value_kept", binary_out, 8'h05);

    // 3: nine digits overflow, then recovery.
    send_str("101010101");
    exp_ovf++;
    send_byte(8'h0A);
    idle(1);
    check_errs("t3");
    check("t3_no_word", out_valid, 0);
    exp_q.push_back(8'h03);
    send_str("11");
    send_byte(8'h0A);
    check("t3_recover_value", binary_out, 8'h03);
    idle(1);

    // 4: illegal character, then a single zero digit.
    send_str("10x1");
    exp_fmt++;
    send_byte(8'h0A);
    idle(1);
    check_errs("t4");
    check("t4_no_word", out_valid, 0);
    exp_q.push_back(8'h00);
    send_str("0");
    send_byte(8'h0A);
    check("t4_zero_valid", out_valid, 1);
    check("t4_zero_value", binary_out, 8'h00);
    idle(1);

    // 4b: high-bit byte is illegal; leading zeros still count as digits.
    send_byte(8'hB1);
    exp_fmt++;
    send_byte(8'h0D);
    idle(1);
    check_errs("t4b");
    exp_q.push_back(8'h01);
    send_str("00000001");
    send_byte(8'h0A);
    check("t4b_leading_zero", binary_out, 8'h01);
    idle(1);

    // 5: overrun with slot full, then same-cycle drain and reload.
    out_ready = 1'b0;
    exp_q.push_back(8'h0F);
    send_str("1111");
    send_byte(8'h0A);
    send_str("1");
    send_byte(8'h0A);
    exp_ovr++;
    idle(1);
    check_errs("t5_overrun");
    check("t5_value_kept", binary_out, 8'h0F);
    check("t5_valid_kept", out_valid, 1);
    send_str("1");
    out_ready = 1'b1;
    exp_q.push_back(8'h01);
    send_byte(8'h0A);
    out_ready = 1'b0;
    check("t5_reload_value", binary_out, 8'h01);
    check("t5_reload_valid", out_valid, 1);
    idle(1);
    check_errs("t5_reload");
    out_ready = 1'b1;
    idle(1);
    check("t5_drained", out_valid, 0);

    // 6: reset with a pending word and a partial word in flight.
    out_ready = 1'b0;
    exp_q.push_back(8'h07);
    send_str("111");
    send_byte(8'h0A);
    send_str("110");
    reset = 1'b1;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_value", binary_out, 0);
    exp_q.delete();
    idle(1);
    reset = 1'b0;
    out_ready = 1'b1;
    exp_q.push_back(8'h01);
    send_str("1");
    send_byte(8'h0A);
    check("t6_after_rst_value", binary_out, 8'h01);
    check("t6_after_rst_valid", out_valid, 1);
    idle(2);
    check("t6_drained", out_valid, 0);
    check_errs("t6");
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
